des_decrypt_key_schedule: RTL and testbench

Generates the 16 DES round subkeys in decryption order (K16 first, K1 last) from a 64-bit key. Applies PC-1 once at load, rotates C/D right per round, and presents PC-2 of the current C/D to the Feistel datapath. It is the decrypt-side counterpart of the encrypt key schedule. It uses the same Select/Finish-flag handshake style as the round XOR units.

---
 rtl/des_decrypt_key_schedule.sv | 175 +++++++++++++++++
 tb/tb_des_decrypt_key_schedule.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/des_decrypt_key_schedule.sv
// DES key schedule issuing round subkeys in decryption order (K16 first, K1 last).
// Build option: define DES_KEY_PARITY_CHECK_EN to reject keys whose bytes lack odd parity.
module des_decrypt_key_schedule #(
  parameter int NUM_ROUNDS = 16  // fixed by DES; do not override
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        KeySched_Start,
  input  logic [64:1] KeySched_Key,
  input  logic        KeySched_Next,
  output logic [48:1] KeySched_Round_Key,
  output logic [4:1]  KeySched_Round_Num,
  output logic        KeySched_Key_Valid,
  output logic        KeySched_Finish_Flag,
  output logic        KeySched_Parity_Error
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);

  // DES bit numbers: PC-1 selects from the 64-bit key, PC-2 from the 56-bit C||D.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  function automatic logic [56:1] pc1(input logic [64:1] key);
    logic [56:1] cd;
    cd = 56'd0;
    for (int i = 0; i < 56; i++) begin
      cd[6'(56 - i)] = key[7'(65 - PC1_TAB[i])];
    end
    return cd;
  endfunction

  function automatic logic [48:1] pc2(input logic [56:1] cd);
    logic [48:1] rk;
    rk = 48'd0;
    for (int i = 0; i < 48; i++) begin
      rk[6'(48 - i)] = cd[6'(57 - PC2_TAB[i])];
    end
    return rk;
  endfunction

`ifdef DES_KEY_PARITY_CHECK_EN
  function automatic logic key_parity_ok(input logic [64:1] key);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      ok = ok & (^key[6'(8 * b + 1) +: 8]);
    end
    return ok;
  endfunction
`endif

  state_t      state_r, state_s;
  logic [28:1] c_r, d_r, c_s, d_s;
  logic [4:0]  round_r, round_s, new_round_s;
  logic        load_s, parity_fail_s;
  logic        key_valid_r, finish_r, parity_err_r;
  logic        key_valid_s, finish_s, parity_err_s;

  // Start acceptance, optionally gated by key byte parity
  always_comb begin
    load_s        = 1'b0;
    parity_fail_s = 1'b0;
    if (state_r == IDLE && KeySched_Start) begin
`ifdef DES_KEY_PARITY_CHECK_EN
      if (key_parity_ok(KeySched_Key)) begin
        load_s = 1'b1;
      end else begin
        parity_fail_s = 1'b1;
      end
`else
      load_s = 1'b1;
`endif
    end else begin
      load_s = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (load_s) state_s = ISSUE; else state_s = IDLE;
      ISSUE:   if (KeySched_Next && round_r == LAST_ROUND) state_s = DONE; else state_s = ISSUE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode, registered below so the flags come straight from flops
  always_comb begin
    key_valid_s  = (state_s == ISSUE);
    finish_s     = (state_s == DONE);
    parity_err_s = parity_fail_s;
  end

  // Output flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_valid_r  <= 1'b0;
      finish_r     <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      key_valid_r  <= key_valid_s;
      finish_r     <= finish_s;
      parity_err_r <= parity_err_s;
    end
  end

  // C/D rotation: right shifts undo the encrypt left shifts, one or two per round
  always_comb begin
    c_s         = c_r;
    d_s         = d_r;
    round_s     = round_r;
    new_round_s = round_r + 5'd1;
    if (load_s) begin
      {c_s, d_s} = pc1(KeySched_Key);
      round_s    = 5'd1;
    end else if (state_r == ISSUE && KeySched_Next) begin
      if (round_r == LAST_ROUND) begin
        round_s = 5'd0;
      end else if (new_round_s == 5'd2 || new_round_s == 5'd9 || new_round_s == 5'd16) begin
        c_s     = {c_r[1], c_r[28:2]};
        d_s     = {d_r[1], d_r[28:2]};
        round_s = new_round_s;
      end else begin
        c_s     = {c_r[2:1], c_r[28:3]};
        d_s     = {d_r[2:1], d_r[28:3]};
        round_s = new_round_s;
      end
    end else begin
      round_s = round_r;
    end
  end

  // C/D and round counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_r     <= 28'd0;
      d_r     <= 28'd0;
      round_r <= 5'd0;
    end else begin
      c_r     <= c_s;
      d_r     <= d_s;
      round_r <= round_s;
    end
  end

  // Round 16 wraps to 4'b0000 on the 4-bit port; Key_Valid distinguishes it from idle.
  assign KeySched_Round_Key    = pc2({c_r, d_r});
  assign KeySched_Round_Num    = round_r[3:0];
  assign KeySched_Key_Valid    = key_valid_r;
  assign KeySched_Finish_Flag  = finish_r;
  assign KeySched_Parity_Error = parity_err_r;

endmodule

// File: tb/tb_des_decrypt_key_schedule.sv
// Bench for des_decrypt_key_schedule: directed vectors plus a reference model built on
// the forward (encrypt) DES key schedule, checked every cycle.
module tb_des_decrypt_key_schedule;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        next = 1'b0;
  logic [64:1] key = 64'd0;
  logic [48:1] round_key;
  logic [4:1]  round_num;
  logic        key_valid, finish, perr;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DES_KEY_PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  des_decrypt_key_schedule dut (
    .clk                   (clk),
    .rst                   (rst),
    .KeySched_Start        (start),
    .KeySched_Key          (key),
    .KeySched_Next         (next),
    .KeySched_Round_Key    (round_key),
    .KeySched_Round_Num    (round_num),
    .KeySched_Key_Valid    (key_valid),
    .KeySched_Finish_Flag  (finish),
    .KeySched_Parity_Error (perr)
  );

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Encrypt-order subkey Kn from the textbook left-shift schedule
  function automatic logic [48:1] enc_subkey(input logic [64:1] k, input int n);
    logic [28:1] c, d;
    logic [56:1] cd;
    logic [48:1] rk;
    for (int i = 0; i < 28; i++) begin
      c[28 - i] = k[65 - PC1[i]];
      d[28 - i] = k[65 - PC1[28 + i]];
    end
    for (int r = 1; r <= n; r++) begin
      for (int s = 0; s < SHIFTS[r - 1]; s++) begin
        c = {c[27:1], c[28]};
        d = {d[27:1], d[28]};
      end
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) rk[48 - i] = cd[57 - PC2[i]];
    return rk;
  endfunction

  function automatic bit bytes_odd(input logic [64:1] k);
    logic [63:0] kk;
    kk = k;
    for (int b = 0; b < 8; b++) begin
      if (($countones((kk >> (8 * b)) & 64'hFF) % 2) == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: phase 0 idle, 1 issuing, 2 finished; round counts in decrypt order
  int          m_phase = 0;
  int          m_round = 0;
  logic [64:1] m_key = 64'd0;
  logic        m_perr = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_round <= 0;
      m_perr  <= 1'b0;
      m_key   <= 64'd0;
    end else begin
      m_perr <= 1'b0;
      if (m_phase == 0) begin
        if (start) begin
          if (PARITY_EN && !bytes_odd(key)) m_perr <= 1'b1;
          else begin
            m_phase <= 1;
            m_round <= 1;
            m_key   <= key;
          end
        end
      end else if (m_phase == 1) begin
        if (next) begin
          if (m_round == 16) begin
            m_phase <= 2;
            m_round <= 0;
          end else m_round <= m_round + 1;
        end
      end else m_phase <= 0;
    end
  end

  always @(negedge clk) begin
    check("valid", key_valid, 64'(m_phase == 1));
    check("finish", finish, 64'(m_phase == 2));
    check("parity_err", perr, 64'(m_perr));
    if (m_phase == 1) begin
      check("round_num", round_num, 64'(m_round % 16));
      check("round_key", round_key, enc_subkey(m_key, 17 - m_round));
    end
  end

  initial begin
    rst = 1'b1;
    #2;
    check("rst_key", round_key, 64'd0);
    check("rst_num", round_num, 64'd0);
    check("rst_valid", key_valid, 64'd0);
    check("rst_finish", finish, 64'd0);
    check("rst_perr", perr, 64'd0);
    repeat (2) tick();
    rst = 1'b0;

    // Test 1: load, K16 one clock after Start
    key = 64'h133457799BBCDFF1;
    check("model_k16", enc_subkey(key, 16), 64'h0000CB3D8B0E17F5);
    check("model_k15", enc_subkey(key, 15), 64'h0000BF918D3D3F0A);
    check("model_k1", enc_subkey(key, 1), 64'h00001B02EFFC7072);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_valid", key_valid, 64'd1);
    check("t1_num", round_num, 64'd1);
    check("t1_k16", round_key, 64'h0000CB3D8B0E17F5);

    // Test 2: one advance
    next = 1'b1;
    tick();
    next = 1'b0;
    check("t2_num", round_num, 64'd2);
    check("t2_k15", round_key, 64'h0000BF918D3D3F0A);

    // Test 3: run to round 16, then DONE, then IDLE (Start in DONE ignored)
    next = 1'b1;
    repeat (14) tick();
    check("t3_num16", round_num, 64'd0);
    check("t3_valid16", key_valid, 64'd1);
    check("t3_k1", round_key, 64'h00001B02EFFC7072);
    tick();
    next  = 1'b0;
    start = 1'b1;
    check("t3_done_valid", key_valid, 64'd0);
    check("t3_done_finish", finish, 64'd1);
    tick();
    start = 1'b0;
    check("t3_idle_valid", key_valid, 64'd0);
    check("t3_idle_finish", finish, 64'd0);

    // Test 4: Start+Next together, hold, ignored Start, reset mid-run
    start = 1'b1;
    next  = 1'b1;
    tick();
    start = 1'b0;
    check("t4_start_wins", round_num, 64'd1);
    repeat (4) tick();
    next = 1'b0;
    repeat (10) tick();
    check("t4_hold_num", round_num, 64'd5);
    check("t4_hold_key", round_key, enc_subkey(key, 12));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_restart_num", round_num, 64'd5);
    next = 1'b1;
    repeat (2) tick();
    next = 1'b0;
    check("t4_num7", round_num, 64'd7);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_key", round_key, 64'd0);
    check("t4_rst_num", round_num, 64'd0);
    check("t4_rst_valid", key_valid, 64'd0);
    check("t4_rst_finish", finish, 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t4_no_finish", finish, 64'd0);
    end

`ifdef DES_KEY_PARITY_CHECK_EN
    // Test 5: even-parity byte rejected, then good key accepted
    key   = 64'h133457799BBCDFF0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_perr", perr, 64'd1);
    check("t5_valid", key_valid, 64'd0);
    tick();
    check("t5_perr_clear", perr, 64'd0);
    check("t5_still_idle", key_valid, 64'd0);
    key   = 64'h133457799BBCDFF1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_valid_ok", key_valid, 64'd1);
    check("t5_k16", round_key, 64'h0000CB3D8B0E17F5);
`else
    // Test 6: parity bits ignored
    key   = 64'h133457799BBCDFF0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_perr", perr, 64'd0);
    check("t6_valid", key_valid, 64'd1);
    check("t6_k16", round_key, 64'h0000CB3D8B0E17F5);
`endif

    next = 1'b1;
    repeat (16) tick();
    next = 1'b0;
    check("end_finish", finish, 64'd1);
    tick();
    check("end_finish_clear", finish, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
